// File: rtl/downcounter_hex_timer_pkg.sv
// rtl/downcounter_hex_timer_pkg.sv - typed view of the shared timer definitions
`include "dct_defs.vh"

package downcounter_hex_timer_pkg;

    localparam int DCT_DIGITS_DEFAULT = `DCT_DIGITS_DEFAULT;

    typedef enum logic [1:0] {
        ST_IDLE  = `DCT_ST_IDLE,
        ST_RUN   = `DCT_ST_RUN,
        ST_PAUSE = `DCT_ST_PAUSE,
        ST_DONE  = `DCT_ST_DONE
    } dct_state_e;

endpackage

// File: rtl/dct_defs.vh
// rtl/dct_defs.vh - shared state encodings and default digit count for the hex down-counter timer
`ifndef DCT_DEFS_VH
`define DCT_DEFS_VH

`define DCT_DIGITS_DEFAULT 4

`define DCT_ST_IDLE  2'd0
`define DCT_ST_RUN   2'd1
`define DCT_ST_PAUSE 2'd2
`define DCT_ST_DONE  2'd3

`endif

// File: rtl/downcounter_hex.sv
// rtl/downcounter_hex.sv - one 4-bit hex digit of the down-counter chain
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   load, load_val parallel load of this digit (load wins over en)
//   en             borrow-in: decrement this digit by one
//   val            registered digit value
//   borrow_out     combinational borrow to the next digit (val == 0 and en)
module downcounter_hex (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic [3:0] val,
    output logic       borrow_out
);

    logic [3:0] val_q;
    logic [3:0] val_d;

    always_comb begin
        val_d = val_q;
        if (load) begin
            val_d = load_val;
        end else if (en) begin
            val_d = val_q - 4'd1;   // 0 wraps to F
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q <= 4'd0;
        end else begin
            val_q <= val_d;
        end
    end

    assign val        = val_q;
    assign borrow_out = en && (val_q == 4'd0);

endmodule

// File: rtl/downcounter_hex_timer.sv
// rtl/downcounter_hex_timer.sv - hex down-counter timer with IDLE/RUN/PAUSE/DONE control
// Optional feature: define DCT_AUTO_RELOAD_EN to reload the count from the last loaded
// value after reaching zero instead of stopping in DONE.
// Ports:
//   dct_clk, dct_rst_n  clock and asynchronous active-low reset
//   dct_tick            count-enable pulse (only honoured in RUN)
//   dct_load/_load_val  load count (and reload value), return to IDLE
//   dct_start           start / resume
//   dct_pause           pause (beats start)
//   dct_out             registered count
//   dct_busy/dct_done   registered state flags for RUN / DONE
//   dct_zero            one-cycle pulse in the first cycle dct_out reads zero
module downcounter_hex_timer
    import downcounter_hex_timer_pkg::*;
#(
    parameter int DIGITS = DCT_DIGITS_DEFAULT
) (
    input  logic                dct_clk,
    input  logic                dct_rst_n,
    input  logic                dct_tick,
    input  logic                dct_load,
    input  logic [4*DIGITS-1:0] dct_load_val,
    input  logic                dct_start,
    input  logic                dct_pause,
    output logic [4*DIGITS-1:0] dct_out,
    output logic                dct_busy,
    output logic                dct_done,
    output logic                dct_zero
);

    localparam int W = 4 * DIGITS;

    dct_state_e   state_q, state_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         zero_q, zero_d;

    logic         dec_en;
    logic         digit_load;
    logic [W-1:0] digit_load_val;
    logic [DIGITS-1:0] en_chain;
    logic [DIGITS-1:0] borrow;
    logic         top_borrow_unused;

`ifdef DCT_AUTO_RELOAD_EN
    logic [W-1:0] reload_q, reload_d;
`endif

    always_comb begin
        state_d        = state_q;
        zero_d         = 1'b0;
        dec_en         = 1'b0;
        digit_load     = 1'b0;
        digit_load_val = dct_load_val;
`ifdef DCT_AUTO_RELOAD_EN
        reload_d       = reload_q;
`endif

        if (dct_load) begin
            digit_load = 1'b1;
            state_d    = ST_IDLE;
`ifdef DCT_AUTO_RELOAD_EN
            reload_d   = dct_load_val;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_PAUSE: begin
                    if (!dct_pause && dct_start) begin
                        if (dct_out != '0) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_DONE;
                            zero_d  = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (dct_pause) begin
                        state_d = ST_PAUSE;
                    end else if (dct_tick) begin
                        if (dct_out == W'(1)) begin
                            dec_en = 1'b1;
                            zero_d = 1'b1;
`ifndef DCT_AUTO_RELOAD_EN
                            state_d = ST_DONE;
`endif
                        end else if (dct_out == '0) begin
                            // Only reachable with auto-reload: the count sat at zero
                            // for one tick period and is now refilled.
`ifdef DCT_AUTO_RELOAD_EN
                            if (reload_q == '0) begin
                                state_d = ST_DONE;
                            end else begin
                                digit_load     = 1'b1;
                                digit_load_val = reload_q;
                            end
`else
                            state_d = ST_DONE;
`endif
                        end else begin
                            dec_en = 1'b1;
                        end
                    end
                end
                default: ;  // DONE: held until load or reset
            endcase
        end

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge dct_clk or negedge dct_rst_n) begin
        if (!dct_rst_n) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            zero_q   <= 1'b0;
`ifdef DCT_AUTO_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            zero_q   <= zero_d;
`ifdef DCT_AUTO_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    // Digit 0 decrements on dec_en; each higher digit decrements on the borrow below it.
    assign en_chain[0] = dec_en;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        downcounter_hex u_digit (
            .clk        (dct_clk),
            .rst_n      (dct_rst_n),
            .load       (digit_load),
            .load_val   (digit_load_val[4*i +: 4]),
            .en         (en_chain[i]),
            .val        (dct_out[4*i +: 4]),
            .borrow_out (borrow[i])
        );
        if (i < DIGITS - 1) begin : g_chain
            assign en_chain[i+1] = borrow[i];
        end
    end

    // The FSM never decrements from zero, so the top borrow never fires.
    assign top_borrow_unused = borrow[DIGITS-1];

    assign dct_busy = busy_q;
    assign dct_done = done_q;
    assign dct_zero = zero_q;

endmodule
